// File: rtl/ai_accel_wb_matrix.sv
// Wishbone-style matrix coprocessor: A/B/C storage, control registers,
// and a one-MAC-per-clock sequencer for multiply and element-wise add.
module ai_accel_wb_matrix #(
    parameter int MAX_DIM = 16,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 15
) (
    input  logic              wishbone_clk_i,
    input  logic              wishbone_rst_i,
    input  logic [31:0]       wishbone_addr_i,
    input  logic              wishbone_we_i,
    input  logic [DATA_W-1:0] wishbone_data_i,
    output logic [DATA_W-1:0] wishbone_data_o,
    output logic              wishbone_ack,
    input  logic              wishbone_stb
);
    localparam int CW = $clog2(MAX_DIM);
    localparam int NW = MAX_DIM * MAX_DIM;
    localparam logic [IDX_W-1:0] DIM_I = IDX_W'(MAX_DIM);
    localparam logic [DATA_W-1:0] DIM_D = DATA_W'(MAX_DIM);
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);
    localparam logic [DATA_W-1:0] TWO = DATA_W'(2);

    typedef enum logic [2:0] {
        IDLE, CLEAR, MAC, STORE, DONE
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] a_mem [NW];
    logic [DATA_W-1:0] b_mem [NW];
    logic [DATA_W-1:0] c_mem [NW];

    logic [DATA_W-1:0] op, wa, ha, wb, hb, acc;
    logic              done, err;
    logic [CW-1:0]     i_q, j_q, k_q;

    logic [1:0]       region;
    logic [IDX_W-1:0] row, col;
    logic [2:0]       sel;
    logic [2*CW-1:0]  bus_idx;
    logic             in_rng, busy, stall, acc_ok, wr, go_wr;
    logic             is_mul, go_ok, last_elem;
    logic [CW-1:0]    i_last, j_last, k_last;

    assign region  = wishbone_addr_i[31:30];
    assign row     = wishbone_addr_i[29:15];
    assign col     = wishbone_addr_i[14:0];
    assign sel     = wishbone_addr_i[2:0];
    assign bus_idx = {row[CW-1:0], col[CW-1:0]};
    assign in_rng  = (row < DIM_I) && (col < DIM_I);

    assign busy   = (state_q == CLEAR) || (state_q == MAC)
                 || (state_q == STORE);
    assign stall  = busy && ((region != 2'b00) || wishbone_we_i);
    assign acc_ok = wishbone_stb && !wishbone_ack && !stall;
    assign wr     = acc_ok && wishbone_we_i;
    assign go_wr  = wr && (region == 2'b00) && (sel == 3'd5);

    function automatic logic dim_ok(input logic [DATA_W-1:0] d);
        return (d != '0) && (d <= DIM_D);
    endfunction

    assign is_mul = (op == ONE);
    assign go_ok  = (is_mul && (wa == hb) && dim_ok(ha)
                     && dim_ok(wa) && dim_ok(wb))
                 || ((op == TWO) && (wa == wb) && (ha == hb)
                     && dim_ok(ha) && dim_ok(wa));

    assign i_last    = CW'(ha - ONE);
    assign j_last    = is_mul ? CW'(wb - ONE) : CW'(wa - ONE);
    assign k_last    = CW'(wa - ONE);
    assign last_elem = (i_q == i_last) && (j_q == j_last);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) state_d = IDLE;
                if (go_wr && go_ok) state_d = is_mul ? CLEAR : STORE;
            end
            CLEAR: state_d = MAC;
            MAC:   if (k_q == k_last) state_d = STORE;
            STORE: begin
                if (last_elem)   state_d = DONE;
                else if (is_mul) state_d = CLEAR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wishbone_clk_i or posedge wishbone_rst_i) begin
        if (wishbone_rst_i) begin
            state_q      <= IDLE;
            wishbone_ack <= 1'b0;
            op   <= '0;
            wa   <= '0;
            ha   <= '0;
            wb   <= '0;
            hb   <= '0;
            acc  <= '0;
            done <= 1'b0;
            err  <= 1'b0;
            i_q  <= '0;
            j_q  <= '0;
            k_q  <= '0;
        end else begin
            state_q      <= state_d;
            wishbone_ack <= acc_ok;
            if (wr && (region == 2'b00)) begin
                unique case (sel)
                    3'd0: op <= wishbone_data_i;
                    3'd1: wa <= wishbone_data_i;
                    3'd2: ha <= wishbone_data_i;
                    3'd3: wb <= wishbone_data_i;
                    3'd4: hb <= wishbone_data_i;
                    default: ;
                endcase
            end
            if (go_wr) begin
                i_q  <= '0;
                j_q  <= '0;
                done <= !go_ok;
                err  <= !go_ok;
            end
            unique case (state_q)
                CLEAR: begin
                    acc <= '0;
                    k_q <= '0;
                end
                MAC: begin
                    acc <= acc + a_mem[{i_q, k_q}] * b_mem[{k_q, j_q}];
                    k_q <= k_q + 1'b1;
                end
                STORE: begin
                    if (j_q == j_last) begin
                        j_q <= '0;
                        i_q <= i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                    if (last_elem) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge wishbone_clk_i) begin
        if (wr && in_rng && (region == 2'b01))
            a_mem[bus_idx] <= wishbone_data_i;
        if (wr && in_rng && (region == 2'b10))
            b_mem[bus_idx] <= wishbone_data_i;
        if (state_q == STORE)
            c_mem[{i_q, j_q}] <= is_mul ? acc
                : a_mem[{i_q, j_q}] + b_mem[{i_q, j_q}];
    end

    always_comb begin
        wishbone_data_o = '0;
        if (wishbone_stb) begin
            unique case (region)
                2'b00: begin
                    unique case (sel)
                        3'd0: wishbone_data_o = op;
                        3'd1: wishbone_data_o = wa;
                        3'd2: wishbone_data_o = ha;
                        3'd3: wishbone_data_o = wb;
                        3'd4: wishbone_data_o = hb;
                        3'd5: wishbone_data_o = {{(DATA_W-3){1'b0}},
                                                 err, done, busy};
                        default: wishbone_data_o = '0;
                    endcase
                end
                2'b01: if (in_rng) wishbone_data_o = a_mem[bus_idx];
                2'b10: if (in_rng) wishbone_data_o = b_mem[bus_idx];
                default: if (in_rng) wishbone_data_o = c_mem[bus_idx];
            endcase
        end
    end
endmodule

// File: tb/tb_ai_accel_wb_matrix.sv
// Directed bench for ai_accel_wb_matrix with a read scoreboard queue.
module tb_ai_accel_wb_matrix;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        stb;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    ai_accel_wb_matrix dut (
        .wishbone_clk_i  (clk),
        .wishbone_rst_i  (rst),
        .wishbone_addr_i (addr),
        .wishbone_we_i   (we),
        .wishbone_data_i (wdata),
        .wishbone_data_o (rdata),
        .wishbone_ack    (ack),
        .wishbone_stb    (stb)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ea(input logic [1:0] rg,
                                       input int r, input int c);
        return {rg, 15'(r), 15'(c)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] q,
                       output int cyc);
        @(negedge clk);
        we = w;
        addr = a;
        wdata = d;
        stb = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!ack && cyc < 20000);
        q = rdata;
        if (!ack) begin
            n_chk++;
            n_fail++;
            $error("FAIL timeout addr=%h got=no_ack expected=ack", a);
        end
        stb = 1'b0;
        we = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      output int cyc);
        logic [31:0] q;
        bus(1'b1, a, d, q, cyc);
    endtask

    task automatic wr0(input logic [31:0] a, input logic [31:0] d);
        int cyc;
        wr(a, d, cyc);
    endtask

    task automatic rd(input string tag, input logic [31:0] a,
                      input logic [31:0] exp, output int cyc);
        logic [31:0] q;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus(1'b0, a, '0, q, cyc);
        chk(tag_q.pop_front(), q, exp_q.pop_front());
    endtask

    task automatic rd0(input string tag, input logic [31:0] a,
                       input logic [31:0] exp);
        int cyc;
        rd(tag, a, exp, cyc);
    endtask

    task automatic set_ctl(input int op, input int w_a, input int h_a,
                           input int w_b, input int h_b);
        wr0(ea(0, 0, 0), 32'(op));
        wr0(ea(0, 0, 1), 32'(w_a));
        wr0(ea(0, 0, 2), 32'(h_a));
        wr0(ea(0, 0, 3), 32'(w_b));
        wr0(ea(0, 0, 4), 32'(h_b));
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        stb = 1'b0;
        we = 1'b0;
        addr = '0;
        wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 6; r++) begin
            rd($sformatf("reset_reg%0d", r), ea(0, 0, r), 32'h0, cyc);
            chk("reset_lat", 32'(cyc), 32'd1);
        end

        set_ctl(1, 15, 15, 15, 15);
        for (int i = 0; i < 15; i++)
            for (int j = 0; j < 15; j++) begin
                wr0(ea(1, i, j), 32'(i));
                wr0(ea(2, i, j), 32'(j));
            end
        wr0(ea(0, 0, 5), 32'hFFFF_FFFF);
        rd("status_busy", ea(0, 0, 5), 32'h1, cyc);
        chk("status_lat", 32'(cyc), 32'd1);
        rd("mul_c23", ea(3, 2, 3), 32'h5A, cyc);
        chk("mul_stalled", 32'(cyc > 100), 32'd1);
        rd0("status_done", ea(0, 0, 5), 32'h2);
        rd0("mul_c1414", ea(3, 14, 14), 32'hB7C);
        for (int j = 0; j < 15; j += 7)
            rd0($sformatf("mul_c0_%0d", j), ea(3, 0, j), 32'h0);

        wr0(ea(0, 0, 1), 32'd3);
        wr0(ea(0, 0, 4), 32'd4);
        wr0(ea(0, 0, 5), 32'd0);
        rd("status_err", ea(0, 0, 5), 32'h6, cyc);
        chk("err_no_busy_lat", 32'(cyc), 32'd1);
        rd0("err_c_kept", ea(3, 2, 3), 32'h5A);

        set_ctl(2, 2, 2, 2, 2);
        wr0(ea(1, 0, 0), 32'd1);
        wr0(ea(1, 0, 1), 32'd2);
        wr0(ea(1, 1, 0), 32'd3);
        wr0(ea(1, 1, 1), 32'hFFFF_FFFF);
        wr0(ea(2, 0, 0), 32'd4);
        wr0(ea(2, 0, 1), 32'd5);
        wr0(ea(2, 1, 0), 32'd6);
        wr0(ea(2, 1, 1), 32'd1);
        wr0(ea(0, 0, 5), 32'd1);
        rd0("add_c00", ea(3, 0, 0), 32'd5);
        rd0("add_c01", ea(3, 0, 1), 32'd7);
        rd0("add_c10", ea(3, 1, 0), 32'd9);
        rd0("add_c11_wrap", ea(3, 1, 1), 32'd0);
        rd0("add_outside_kept", ea(3, 2, 3), 32'h5A);
        rd0("add_status", ea(0, 0, 5), 32'h2);

        wr(ea(1, 20, 0), 32'hDEAD_BEEF, cyc);
        chk("oob_wr_lat", 32'(cyc), 32'd1);
        rd0("oob_rd", ea(1, 20, 0), 32'h0);
        rd0("oob_no_alias", ea(1, 4, 0), 32'd4);
        wr0(ea(3, 0, 0), 32'h1234_5678);
        rd0("c_readonly", ea(3, 0, 0), 32'd5);
        wr0(ea(0, 0, 6), 32'h1234_5678);
        rd0("ctl6", ea(0, 0, 6), 32'h0);

        set_ctl(1, 15, 15, 15, 15);
        wr0(ea(0, 0, 5), 32'd1);
        repeat (50) @(posedge clk);
        #2;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        rd0("rst_status", ea(0, 0, 5), 32'h0);
        rd0("rst_op", ea(0, 0, 0), 32'h0);
        rd0("rst_wa", ea(0, 0, 1), 32'h0);

        set_ctl(1, 2, 2, 2, 2);
        wr0(ea(0, 0, 5), 32'd1);
        rd0("mul2_c00", ea(3, 0, 0), 32'd16);
        rd0("mul2_c01", ea(3, 0, 1), 32'd7);
        rd0("mul2_c10", ea(3, 1, 0), 32'd6);
        rd0("mul2_c11", ea(3, 1, 1), 32'd14);
        rd0("mul2_status", ea(0, 0, 5), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ai_accel_wb_matrix.md
Name: ai_accel_wb_matrix

Overview:
Memory-mapped matrix coprocessor on a classic Wishbone-style slave port. The host writes matrices A and B and the operation/dimension registers, then writes GO. An internal sequencer computes C with one multiply-accumulate per clock. The host then reads C back over the same bus. The block sits as a peripheral slave on the SoC system bus.

Parameters:
MAX_DIM, 16, maximum rows/columns per matrix; storage is MAX_DIM x MAX_DIM words per matrix.
DATA_W, 32, element width and bus data width.
IDX_W, 15, width of each row/column index field in the address.

Ports:
wishbone_clk_i  in  1  single clock; all state changes on the rising edge.
wishbone_rst_i  in  1  asynchronous, active-high reset.
wishbone_addr_i  in  32  [31:30] region select, [29:15] row index, [14:0] column index.
wishbone_we_i  in  1  1 = write, 0 = read; qualified by stb.
wishbone_data_i  in  32  write data.
wishbone_data_o  out  32  read data.
wishbone_ack  out  1  transfer-complete strobe.
wishbone_stb  in  1  transfer request; held high until ack is seen.

Behaviour:
- Regions (addr[31:30]):
  - 00 = control.
  - 01 = A.
  - 10 = B.
  - 11 = C, read-only; writes are acked and ignored.
  - Element address = (row = addr[29:15], col = addr[14:0]).
  - Row or col >= MAX_DIM: write ignored, read returns 0, still acked.
- Control words (addr[2:0] in region 00; upper bits ignored):
  - 0 = OP. 1 = WA (width A). 2 = HA (height A). 3 = WB. 4 = HB. All read/write, 32 bits.
  - 5 = GO/STATUS. Any write starts the operation. Read returns {29'b0, err, done, busy}.
  - 6, 7: reads return 0, writes ignored.
- OP encoding:
  - 1 = multiply, C = A x B, C is HA x WB.
  - 2 = element-wise add, C = A + B, C is HA x WA.
  - Any other value sets err and completes immediately, C untouched.
- Dimension check at GO:
  - Multiply requires WA == HB.
  - Add requires WA == WB and HA == HB.
  - All dimensions used must be in 1..MAX_DIM.
  - On failure: err = 1, done = 1, busy never set.
- Handshake:
  - ack is registered: ack <= stb & ~ack. It pulses high for one cycle on the edge after stb is sampled high.
  - If stb stays high, ack repeats every other cycle.
  - Writes commit on the same edge that raises ack.
  - wishbone_data_o is combinational from addr (asynchronous read of storage/registers), so it is valid before and during ack. It is 0 when stb is low.
- Stall: while busy, any access to regions 01/10/11 and any write to control words 0-5 gets no ack until busy falls; then it is serviced normally.
  - Reads of control words are always serviced, so the host can poll STATUS.
  - Writes to GO while busy are stalled, never restart.
- Sequencer states: IDLE -> (GO, check ok) CLEAR -> MAC -> STORE -> next element or DONE -> IDLE.
  - Multiply: for each (i, j) in row-major order, acc = 0, then for k = 0..WA-1 add A[i][k]*B[k][j] one product per clock, then write C[i][j].
  - Add: one element per clock.
  - busy = 1 from the edge after the GO write until the final C write. Then done = 1, busy = 0.
  - GO clears done and err.
- Arithmetic: 32x32 product and sum, truncated to the low 32 bits (two's-complement wrap). Same bit result for signed and unsigned inputs.
- C elements outside the result region keep their previous contents.
- Reset (any time, including mid-operation):
  - ack = 0.
  - OP, WA, HA, WB, HB = 0.
  - busy, done, err = 0; the sequencer returns to IDLE and the computation is abandoned.
  - A/B/C storage is not reset; its contents are undefined until written.

Test Plan:
- Reset, then read addr 0..5 -> all 0; each access acked exactly one cycle after stb is sampled high.
- Write OP=1, WA=HA=WB=HB=15; A[i][j]=i, B[i][j]=j for i,j in 0..14; write GO=0xFFFFFFFF; immediately read C[2][3] -> ack stalls until done, then data 0x5A; C[14][14] = 0xB7C; C[0][j] = 0.
- Poll STATUS during the above multiply -> 0x1 (busy), after completion 0x2 (done).
- OP=1, WA=3, HB=4, GO -> STATUS 0x6 (err, done) with no busy; C unchanged.
- OP=2, 2x2, A = {1,2,3,0xFFFFFFFF}, B = {4,5,6,1}, GO -> C = {5,7,9,0} (wrap).
- Write A row 20 (>= MAX_DIM) -> acked, no effect; read -> 0. Assert reset mid-multiply -> STATUS 0, new GO runs correctly.
